// File: rtl/uart_system.sv
// rtl/uart_system.sv - full-duplex UART, independent transmitter and receiver, single-byte handshake
//
// Frame: start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1).
// Every bit lasts BIT_TICKS = CLK_FREQ/BAUD_RATE clocks (truncated).
//
// Ports:
//   clk                   system clock, rising edge
//   rstN                  asynchronous active-low reset
//   txByteStart           transmit request, honoured only while tx_ready=1
//   byteForTx             byte to send, captured in the accept cycle
//   rx                    asynchronous serial input, idle high
//   tx                    serial output, idle high
//   tx_ready              transmitter idle
//   rx_ready              receiver idle, waiting for a start bit
//   rx_new_byte_started   one-cycle pulse on a confirmed start bit
//   rx_new_byte_received  one-cycle pulse, byteFromRx holds a correctly framed byte
//   byteFromRx            last good byte, held until the next good frame
module uart_system #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 19200,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  txByteStart,
  input  logic [DATA_WIDTH-1:0] byteForTx,
  input  logic                  rx,
  output logic                  tx,
  output logic                  tx_ready,
  output logic                  rx_ready,
  output logic                  rx_new_byte_started,
  output logic                  rx_new_byte_received,
  output logic [DATA_WIDTH-1:0] byteFromRx
);

  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W     = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BIT_TICKS - 1);
  // The start bit is re-checked half a bit after the falling edge; every later
  // sample then lands one full bit further on, i.e. mid-bit.
  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(BIT_TICKS / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

  txState_t              txState, txStateNext;
  logic [CNT_W-1:0]      txCnt, txCntNext;
  logic [IDX_W-1:0]      txIdx, txIdxNext;
  logic [DATA_WIDTH-1:0] txShift, txShiftNext;
  logic                  txNext, txReadyNext;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      txState  <= TX_IDLE;
      txCnt    <= '0;
      txIdx    <= '0;
      txShift  <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      txState  <= txStateNext;
      txCnt    <= txCntNext;
      txIdx    <= txIdxNext;
      txShift  <= txShiftNext;
      tx       <= txNext;
      tx_ready <= txReadyNext;
    end
  end

  // tx is registered: each branch drives the line level of the bit being entered.
  always_comb begin
    txStateNext = txState;
    txCntNext   = txCnt;
    txIdxNext   = txIdx;
    txShiftNext = txShift;
    txNext      = tx;
    txReadyNext = tx_ready;
    case (txState)
      TX_IDLE: begin
        txNext      = 1'b1;
        txReadyNext = 1'b1;
        if (txByteStart) begin
          txStateNext = TX_START;
          txShiftNext = byteForTx;
          txCntNext   = '0;
          txNext      = 1'b0;
          txReadyNext = 1'b0;
        end
      end
      TX_START: begin
        if (txCnt == LAST_TICK) begin
          txStateNext = TX_DATA;
          txCntNext   = '0;
          txIdxNext   = '0;
          txNext      = txShift[0];
        end else begin
          txCntNext = txCnt + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (txCnt == LAST_TICK) begin
          txCntNext = '0;
          if (txIdx == LAST_BIT) begin
            txStateNext = TX_STOP;
            txNext      = 1'b1;
          end else begin
            txIdxNext   = txIdx + IDX_ONE;
            txShiftNext = txShift >> 1;
            txNext      = txShiftNext[0];
          end
        end else begin
          txCntNext = txCnt + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (txCnt == LAST_TICK) begin
          txStateNext = TX_IDLE;
          txCntNext   = '0;
          txNext      = 1'b1;
          txReadyNext = 1'b1;
        end else begin
          txCntNext = txCnt + CNT_ONE;
        end
      end
      default: begin
        txStateNext = TX_IDLE;
        txNext      = 1'b1;
        txReadyNext = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- receiver
  // RX_BREAK waits for the line to go high again after a frame whose stop bit was 0.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rxState_t;

  rxState_t              rxState, rxStateNext;
  logic                  rxMeta, rxSync;
  logic [CNT_W-1:0]      rxCnt, rxCntNext;
  logic [IDX_W-1:0]      rxIdx, rxIdxNext;
  logic [DATA_WIDTH-1:0] rxShift, rxShiftNext;
  logic [DATA_WIDTH-1:0] byteNext;
  logic                  startedNext, receivedNext;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxMeta               <= 1'b1;
      rxSync               <= 1'b1;
      rxState              <= RX_IDLE;
      rxCnt                <= '0;
      rxIdx                <= '0;
      rxShift              <= '0;
      byteFromRx           <= '0;
      rx_ready             <= 1'b1;
      rx_new_byte_started  <= 1'b0;
      rx_new_byte_received <= 1'b0;
    end else begin
      rxMeta               <= rx;
      rxSync               <= rxMeta;
      rxState              <= rxStateNext;
      rxCnt                <= rxCntNext;
      rxIdx                <= rxIdxNext;
      rxShift              <= rxShiftNext;
      byteFromRx           <= byteNext;
      rx_ready             <= (rxStateNext == RX_IDLE);
      rx_new_byte_started  <= startedNext;
      rx_new_byte_received <= receivedNext;
    end
  end

  always_comb begin
    rxStateNext  = rxState;
    rxCntNext    = rxCnt;
    rxIdxNext    = rxIdx;
    rxShiftNext  = rxShift;
    byteNext     = byteFromRx;
    startedNext  = 1'b0;
    receivedNext = 1'b0;
    case (rxState)
      RX_IDLE: begin
        if (!rxSync) begin
          rxStateNext = RX_START;
          rxCntNext   = '0;
        end
      end
      RX_START: begin
        if (rxCnt == HALF_TICK) begin
          rxCntNext = '0;
          if (!rxSync) begin
            rxStateNext = RX_DATA;
            rxIdxNext   = '0;
            startedNext = 1'b1;
          end else begin
            rxStateNext = RX_IDLE;
          end
        end else begin
          rxCntNext = rxCnt + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rxCnt == LAST_TICK) begin
          rxCntNext   = '0;
          rxShiftNext = {rxSync, rxShift[DATA_WIDTH-1:1]};
          if (rxIdx == LAST_BIT) rxStateNext = RX_STOP;
          else                   rxIdxNext   = rxIdx + IDX_ONE;
        end else begin
          rxCntNext = rxCnt + CNT_ONE;
        end
      end
      RX_STOP: begin
        // Leaving at mid-stop keeps the receiver armed for an immediately following start bit.
        if (rxCnt == LAST_TICK) begin
          rxCntNext = '0;
          if (rxSync) begin
            rxStateNext  = RX_IDLE;
            byteNext     = rxShift;
            receivedNext = 1'b1;
          end else begin
            rxStateNext = RX_BREAK;
          end
        end else begin
          rxCntNext = rxCnt + CNT_ONE;
        end
      end
      RX_BREAK: begin
        if (rxSync) rxStateNext = RX_IDLE;
      end
      default: rxStateNext = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_system.sv
// tb/tb_uart_system.sv - randomized self-checking bench for uart_system
module tb_uart_system;

  localparam int DW   = 8;
  localparam int BAUD = 10_000;
  localparam int CLKF = 170_000;
  localparam int BT   = CLKF / BAUD;   // 17 clocks per bit, odd on purpose
  localparam int HALF = BT / 2;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          txByteStart = 1'b0;
  logic [DW-1:0] byteForTx = '0;
  logic          rx = 1'b1;
  logic          tx;
  logic          tx_ready;
  logic          rx_ready;
  logic          rx_new_byte_started;
  logic          rx_new_byte_received;
  logic [DW-1:0] byteFromRx;

  uart_system #(.DATA_WIDTH(DW), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF)) dut (
    .clk                  (clk),
    .rstN                 (rstN),
    .txByteStart          (txByteStart),
    .byteForTx            (byteForTx),
    .rx                   (rx),
    .tx                   (tx),
    .tx_ready             (tx_ready),
    .rx_ready             (rx_ready),
    .rx_new_byte_started  (rx_new_byte_started),
    .rx_new_byte_received (rx_new_byte_received),
    .byteFromRx           (byteFromRx)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: line level of bit k (0 = start, 1..DW = data LSB first, DW+1 = stop).
  function automatic logic frameBit(input logic [DW-1:0] b, input int k, input logic stopBit);
    logic [DW+1:0] f;
    f = {stopBit, b, 1'b0};
    return f[k];
  endfunction

  // ---------------------------------------------------------------- receive monitor
  int            cyc = 0;
  int            startCnt = 0, startCyc = 0, rcvCyc = 0, widthErr = 0, fallCyc = 0;
  logic          prevS = 1'b0, prevR = 1'b0;
  logic [DW-1:0] rxQ[$];
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] lastGood = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_new_byte_received) begin
      rxQ.push_back(byteFromRx);
      rcvCyc = cyc;
    end
    if (rx_new_byte_started) begin
      startCnt++;
      startCyc = cyc;
    end
    if ((rx_new_byte_received && prevR) || (rx_new_byte_started && prevS)) widthErr++;
    prevR = rx_new_byte_received;
    prevS = rx_new_byte_started;
  end

  // ---------------------------------------------------------------- stimulus tasks
  task automatic waitTxReady();
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 30 * BT) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) checkVal("txReadyTimeout", 32'(tx_ready), 32'd1);
  endtask

  // Sends one byte and checks every bit mid-period, the busy window and tx_ready return.
  // hold keeps the request high across the frame; poke issues a stray request mid-frame.
  task automatic txFrame(input logic [DW-1:0] b, input bit hold, input bit poke);
    waitTxReady();
    txByteStart = 1'b1;
    byteForTx   = b;
    for (int c = 1; c <= (DW + 2) * BT + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkVal("txBusy", 32'(tx_ready), 32'd0);
        if (!hold) txByteStart = 1'b0;
      end
      if (poke && c == 3 * BT) begin
        txByteStart = 1'b1;
        byteForTx   = ~b;
      end
      if (poke && c == 3 * BT + 1) txByteStart = 1'b0;
      if ((c - 1) % BT == HALF)
        checkVal($sformatf("txBit%0d_byte%02h", (c - 1) / BT, b), 32'(tx),
                 32'(frameBit(b, (c - 1) / BT, 1'b1)));
      if (c == (DW + 2) * BT)     checkVal("txReadyLate", 32'(tx_ready), 32'd0);
      if (c == (DW + 2) * BT + 1) checkVal("txReadyBack", 32'(tx_ready), 32'd1);
    end
    if (hold) begin
      @(negedge clk);
      checkVal("txHeldRestartReady", 32'(tx_ready), 32'd0);
      checkVal("txHeldRestartLine", 32'(tx), 32'd0);
      txByteStart = 1'b0;
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      checkVal("txPokeIgnored", 32'(tx_ready), 32'd1);
    end
  endtask

  // Drives one frame on rx; must be entered at a negedge, and returns at one.
  task automatic rxFrame(input logic [DW-1:0] b, input logic stopBit);
    fallCyc = cyc;
    for (int k = 0; k < DW + 2; k++) begin
      rx = frameBit(b, k, stopBit);
      repeat (BT) @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------- test sequence
  initial begin
    int d;
    int s0;
    logic [DW-1:0] b;

    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rstTx", 32'(tx), 32'd1);
    checkVal("rstTxReady", 32'(tx_ready), 32'd1);
    checkVal("rstRxReady", 32'(rx_ready), 32'd1);
    checkVal("rstStarted", 32'(rx_new_byte_started), 32'd0);
    checkVal("rstReceived", 32'(rx_new_byte_received), 32'd0);
    checkVal("rstByte", 32'(byteFromRx), 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    // single known byte
    txFrame(8'hA5, 1'b0, 1'b0);

    // back-to-back random bytes, one stray request while busy, one held request
    for (int i = 0; i < 10; i++) txFrame(8'($urandom), 1'b0, (i == 3));
    txFrame(8'($urandom), 1'b1, 1'b0);
    waitTxReady();

    // single known receive frame with timing windows
    rxQ.delete();
    rx = 1'b1;
    @(negedge clk);
    rxFrame(8'h3C, 1'b1);
    lastGood = 8'h3C;
    repeat (BT) @(negedge clk);
    checkVal("rx3cCount", 32'(rxQ.size()), 32'd1);
    if (rxQ.size() > 0) checkVal("rx3cValue", 32'(rxQ[0]), 32'h3C);
    d = startCyc - fallCyc;
    checkVal($sformatf("rxStartDelay=%0d", d), 32'(d >= HALF && d < BT), 32'd1);
    d = rcvCyc - fallCyc;
    checkVal($sformatf("rxRecvDelay=%0d", d),
             32'(d >= (DW + 1) * BT + HALF && d < (DW + 2) * BT), 32'd1);
    checkVal("rx3cReady", 32'(rx_ready), 32'd1);

    // back-to-back random receive frames while the transmitter runs
    rxQ.delete();
    expQ.delete();
    s0 = startCnt;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [DW-1:0] r;
          r = 8'($urandom);
          expQ.push_back(r);
          rxFrame(r, 1'b1);
        end
      end
      begin
        for (int j = 0; j < 4; j++) txFrame(8'($urandom), 1'b0, 1'b0);
      end
    join
    repeat (BT) @(negedge clk);
    lastGood = expQ[expQ.size() - 1];
    checkVal("rxB2bStarts", 32'(startCnt - s0), 32'd10);
    checkVal("rxB2bCount", 32'(rxQ.size()), 32'd10);
    for (int i = 0; i < 10 && i < rxQ.size(); i++)
      checkVal($sformatf("rxB2bValue%0d", i), 32'(rxQ[i]), 32'(expQ[i]));
    checkVal("rxPulseWidth", 32'(widthErr), 32'd0);

    // glitch shorter than half a bit
    rxQ.delete();
    s0 = startCnt;
    rx = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BT) @(negedge clk);
    checkVal("glitchStarts", 32'(startCnt - s0), 32'd0);
    checkVal("glitchRecv", 32'(rxQ.size()), 32'd0);
    checkVal("glitchReady", 32'(rx_ready), 32'd1);

    // framing error: stop bit 0, line held low, then released
    b = 8'($urandom);
    rxFrame(b, 1'b0);
    repeat (BT) @(negedge clk);
    checkVal("breakReadyLow", 32'(rx_ready), 32'd0);
    rx = 1'b1;
    repeat (BT) @(negedge clk);
    checkVal("framingRecv", 32'(rxQ.size()), 32'd0);
    checkVal("framingByteHeld", 32'(byteFromRx), 32'(lastGood));
    checkVal("framingReady", 32'(rx_ready), 32'd1);
    b = 8'($urandom);
    rxFrame(b, 1'b1);
    repeat (BT) @(negedge clk);
    checkVal("recoverCount", 32'(rxQ.size()), 32'd1);
    if (rxQ.size() > 0) checkVal("recoverValue", 32'(rxQ[0]), 32'(b));

    // reset in the middle of a transmit and a receive frame
    rxQ.delete();
    byteForTx   = 8'h00;
    txByteStart = 1'b1;
    rx          = 1'b0;
    @(negedge clk);
    txByteStart = 1'b0;
    repeat (3 * BT) @(negedge clk);
    checkVal("midTxBusy", 32'(tx_ready), 32'd0);
    checkVal("midRxBusy", 32'(rx_ready), 32'd0);
    rstN = 1'b0;
    #1;
    checkVal("midRstTx", 32'(tx), 32'd1);
    checkVal("midRstTxReady", 32'(tx_ready), 32'd1);
    checkVal("midRstRxReady", 32'(rx_ready), 32'd1);
    checkVal("midRstStarted", 32'(rx_new_byte_started), 32'd0);
    checkVal("midRstReceived", 32'(rx_new_byte_received), 32'd0);
    checkVal("midRstByte", 32'(byteFromRx), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rstN = 1'b1;
    repeat (12 * BT) @(negedge clk);
    checkVal("postRstRecv", 32'(rxQ.size()), 32'd0);
    checkVal("postRstTxReady", 32'(tx_ready), 32'd1);
    checkVal("postRstTxLine", 32'(tx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
